fwd_scoreboard: RTL
===================

# fwd_scoreboard

Parametrised forwarding and hazard unit for the pipelined core. It tracks every in-flight register writer from EX to the last pre-commit stage in a shift-register scoreboard, where each writer has its own result latency. From that state it decides, per source operand of the instruction in ID, which stage feeds the EX operand mux, or whether ID must stall. Forward selects are resolved in ID and registered into EX, so the EX-stage mux select comes straight from a flop.

## Interface
Parameters:
- NUM_SRC, 2, source operands per instruction.
- DEPTH, 2, forwardable stages after EX (slot 1 = MEM … slot DEPTH = WB).
- MAX_LAT, 2, largest legal result latency; must be ≤ DEPTH.
- AW, 5, register address width.
- SEL_W, $clog2(DEPTH+1), forward-select width (derived).
- LAT_W, $clog2(MAX_LAT+1), latency field width (derived).

Ports:
- clk, input, 1, core clock. One clock; all state on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- id_valid, input, 1, ID holds a real instruction.
- id_rs, input, NUM_SRC*AW, source register numbers; operand i is at [i*AW +: AW].
- id_rd, input, AW, destination register.
- id_wen, input, 1, the ID instruction writes id_rd.
- id_lat, input, LAT_W, stages after EX until the result is forwardable (ALU=1, load=2).
- hold_i, input, 1, freeze the whole EX+ pipeline, e.g. a multicycle unit is busy.
- flush_i, input, 1, squash the ID instruction (branch resolved in EX).
- stall_o, output, 1, ID/IF must not advance this cycle.
- fwd_sel_o, output, NUM_SRC*SEL_W, registered EX operand select per source: 0 = register file, k = slot k.
- stall_cnt_o, output, 32, stall-cycle counter. Present only with FWD_STALL_CNT_EN.

## Operation
- The scoreboard has slots 0..DEPTH; slot 0 is EX. Each slot holds valid, rd, wen and cnt.
- cnt is the number of advances left until the result is on the forwarding bus. A slot is ready when cnt == 0.
- Match rule: ID operand rs matches slot j (0 ≤ j < DEPTH) when valid, wen and rd == rs, with rs ≠ 0.
- Slot DEPTH (the committing stage) is not compared. The register file is write-before-read.
- Priority: the youngest matching slot (smallest j) wins. Older matches are ignored.
- Hazard: the winning slot j has cnt > 1, meaning its data is not ready when the consumer reaches EX. stall_o is the OR over all operands, gated by id_valid and masked by flush_i.
- Select for operand i:
  - j+1 when a ready match exists;
  - otherwise 0.
- Advance happens every cycle with hold_i == 0:
  - slots 1..DEPTH take slots 0..DEPTH-1;
  - each moved cnt decrements, saturating at 0.
- Slot 0 loads on advance:
  - the ID instruction (valid=1, cnt=min(id_lat, DEPTH)) when id_valid && !stall_o && !flush_i;
  - otherwise a bubble (valid=0).
- fwd_sel_o loads on advance: the computed selects for an issued instruction, all zeros for a bubble.
- While hold_i == 1, all slots, fwd_sel_o and the counter keep their values. stall_o is still computed from the frozen state.
- An id_lat value above DEPTH is clamped to DEPTH.

## Timing
- Reset (async, reset_n low): all slots invalid with cnt=0, fwd_sel_o=0, stall_cnt_o=0.
- Reset is released synchronously to clk by the top level.
- stall_o is combinational from the ID inputs and scoreboard state, valid in the same cycle.
- fwd_sel_o is valid in the cycle the consumer occupies EX, one clock after its ID cycle.
- Load-use with lat=2 and DEPTH=2: exactly one stall cycle, then fwd_sel=2.
- A lat=3 producer directly ahead of its consumer (DEPTH=3) costs two stall cycles.
- flush_i together with a hazard: flush wins. stall_o=0 and a bubble enters slot 0.
- Reset mid-stall: state clears immediately and stall_o drops in the same cycle.

## Configuration
- FWD_STALL_CNT_EN defined: stall_cnt_o is a 32-bit counter that increments on every cycle with stall_o && !hold_i, wraps at 2^32-1 → 0, and resets to 0.
- Macro undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Test plan
All scenarios use defaults unless stated.
- ALU writer x5 (lat 1), consumer rs1=x5 next: stall_o=0; next cycle fwd_sel_o[0]=1.
- Load x6 (lat 2), consumer rs2=x6 next: stall_o=1 for one cycle and slot 0 takes a bubble; consumer then reaches EX with fwd_sel_o[1]=2.
- Writers x7 (ALU) then x7 (ALU), consumer rs1=x7: youngest wins, fwd_sel_o[0]=1. The x0 case: rd=0 writer with rs1=0 → stall_o=0, sel 0.
- Load-use hazard with hold_i=1 for 3 cycles: stall_o stays 1, and fwd_sel_o and all slots are unchanged. hold_i drops → one more stall cycle, then sel=2.
- Flush and reset:
  - flush_i during a load-use hazard: stall_o=0, slot 0 bubble, fwd_sel_o=0.
  - reset_n pulsed low mid-sequence: fwd_sel_o=0 and stall_o=0 immediately.
- With FWD_STALL_CNT_EN: three load-use pairs → stall_cnt_o=3.
  - hold cycles are not counted;
  - counter preset near wrap: 0xFFFFFFFF → 0 on the next stall cycle.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: forwarding and hazard unit for the pipelined core.
//
// A shift-register scoreboard tracks every in-flight register writer from EX
// (slot 0) to the committing stage (slot DEPTH). Each slot carries the
// writer's destination and a countdown of advances until its result reaches
// the forwarding bus. The ID-stage operands are compared against slots
// 0..DEPTH-1, and the youngest match decides the outcome:
//   - a result not ready by the time the consumer reaches EX causes a stall;
//   - otherwise the matching slot number + 1 becomes the EX operand select.
// Selects are registered on issue, so the EX-stage mux is driven from a flop.
//
// Optional feature: define FWD_STALL_CNT_EN to add the 32-bit stall_cnt_o
// counter. It counts cycles in which stall_o is high and hold_i is low.
// The default build leaves the macro undefined and has no counter port.

module fwd_scoreboard #(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2,
   parameter int MAX_LAT = 2,
   parameter int AW      = 5,
   parameter int SEL_W   = $clog2(DEPTH + 1),
   parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     id_valid,
   input  logic [NUM_SRC*AW-1:0]    id_rs,
   input  logic [AW-1:0]            id_rd,
   input  logic                     id_wen,
   input  logic [LAT_W-1:0]         id_lat,
   input  logic                     hold_i,
   input  logic                     flush_i,
   output logic                     stall_o,
   output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o
`ifdef FWD_STALL_CNT_EN
   ,
   output logic [31:0]              stall_cnt_o
`endif
);

   // The countdown is clamped to DEPTH, so it shares the select width.
   localparam int CNT_W = SEL_W;

   typedef struct packed {
      logic             valid;
      logic             wen;
      logic [AW-1:0]    rd;
      logic [CNT_W-1:0] cnt;
   } slot_t;

   // Scoreboard: slot 0 = EX, slot DEPTH = committing stage.
   slot_t                    slot_q [DEPTH+1];
   slot_t                    slot0_d;
   logic [CNT_W-1:0]         lat_clamped;
   logic [NUM_SRC-1:0]       hazard;
   logic [NUM_SRC*SEL_W-1:0] sel_d;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel_q;
   logic                     stall;
   logic                     issue;

   // A slot forwards to operand rs when it holds a live writer of rs.
   // Register 0 is hard-wired, so it never creates a dependency.
   function automatic logic slot_match(input slot_t s, input logic [AW-1:0] rs);
      return s.valid && s.wen && (s.rd == rs) && (rs != '0);
   endfunction

   // Moving one stage closer to commit consumes one advance of latency.
   function automatic slot_t age_slot(input slot_t s);
      slot_t r;
      r = s;
      if (s.cnt != '0) begin
         r.cnt = s.cnt - CNT_W'(1);
      end
      return r;
   endfunction

   // Per-operand lookup: find the youngest matching slot and classify it.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [AW-1:0]    rs;
      logic             hit;
      logic [SEL_W-1:0] win_sel;
      logic [CNT_W-1:0] win_cnt;

      assign rs = id_rs[i*AW +: AW];

      // Scan from oldest to youngest so the youngest hit overrides older ones.
      always_comb begin
         // NOTE: every variable gets a default before the loop; a path that
         // leaves one unassigned would infer a latch.
         hit     = 1'b0;
         win_sel = '0;
         win_cnt = '0;
         for (int j = DEPTH - 1; j >= 0; j--) begin
            if (slot_match(slot_q[j], rs)) begin
               hit     = 1'b1;
               win_sel = SEL_W'(j + 1);
               win_cnt = slot_q[j].cnt;
            end
         end
      end

      // More than one advance left means the data misses the consumer's EX.
      assign hazard[i]                = hit && (win_cnt > CNT_W'(1));
      assign sel_d[i*SEL_W +: SEL_W]  = (hit && !hazard[i]) ? win_sel : '0;
   end

   // Stall and issue decisions; a flush squashes the ID instruction outright.
   always_comb begin
      stall = id_valid && !flush_i && (|hazard);
      issue = id_valid && !flush_i && !(|hazard);
   end

   assign stall_o = stall;

   // Clamp the requested latency to the depth the scoreboard can express.
   always_comb begin
      if (32'(id_lat) > DEPTH) begin
         lat_clamped = CNT_W'(DEPTH);
      end else begin
         lat_clamped = CNT_W'(id_lat);
      end
   end

   // Slot 0 entry: the issuing ID instruction, or a bubble.
   always_comb begin
      slot0_d = '0;
      if (issue) begin
         slot0_d.valid = 1'b1;
         slot0_d.wen   = id_wen;
         slot0_d.rd    = id_rd;
         slot0_d.cnt   = lat_clamped;
      end
   end

   // Scoreboard shift register; frozen while hold_i is high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the slot array is a handful of flops whose valid bits gate
         // every comparison, so every entry is cleared on reset, not just
         // the valid bits.
         for (int k = 0; k <= DEPTH; k++) begin
            slot_q[k] <= '0;
         end
      end else if (!hold_i) begin
         // NOTE: non-blocking assignments let every slot sample the old value
         // of its predecessor, which is what makes this a shift register.
         slot_q[0] <= slot0_d;
         for (int k = 1; k <= DEPTH; k++) begin
            slot_q[k] <= age_slot(slot_q[k-1]);
         end
      end
   end

   // EX operand selects: loaded with the issuing instruction's selects.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fwd_sel_q <= '0;
      end else if (!hold_i) begin
         fwd_sel_q <= issue ? sel_d : '0;
      end
   end

   assign fwd_sel_o = fwd_sel_q;

`ifdef FWD_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   // Stall-cycle counter; frozen cycles are not counted, wraps naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
      end else if (stall && !hold_i) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
